// File: rtl/lock_access_controller.sv
// Serial code entry with a programmable code register, a timed unlock
// window, consecutive-failure counting and a timed lockout.
module lock_access_controller #(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b1101,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  OPEN_CYCLES    = 500,
    parameter int                  LOCKOUT_CYCLES = 1000,
    parameter int                  ENTRY_TIMEOUT  = 200,
    parameter int                  CNT_W          = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           bit_valid,
    input  logic                           bit_in,
    input  logic                           lock_req,
    input  logic                           prog_req,
    input  logic [CODE_LEN-1:0]            prog_code,
    output logic                           unlock,
    output logic                           locked_out,
    output logic                           fail_pulse,
    output logic                           prog_ack,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int FC_W = $clog2(MAX_FAILS + 1);
    localparam int BC_W = $clog2(CODE_LEN + 1);

    localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(CODE_LEN - 1);
    localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ENTRY_TIMEOUT - 1);
    localparam logic [FC_W-1:0]  FAIL_MAX  = FC_W'(MAX_FAILS);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        OPEN,
        LOCKOUT
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [CODE_LEN-1:0] shift_q;
    logic [CODE_LEN-1:0] code_q;
    logic [BC_W-1:0]     bit_cnt_q;
    logic [CNT_W-1:0]    timer_q;
    logic [FC_W-1:0]     fail_cnt_q;
    logic                fail_pulse_q;
    logic                prog_ack_q;

    logic                bit_accept;
    logic                entry_done;
    logic                entry_tmo;
    logic                idle_tick;
    logic                code_match;
    logic                lock_hit;
    logic [FC_W-1:0]     fail_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_accept = 1'b0;
        entry_done = 1'b0;
        entry_tmo  = 1'b0;
        idle_tick  = 1'b0;
        code_match = (shift_q == code_q);
        fail_next  = fail_cnt_q + 1'b1;
        lock_hit   = (fail_next == FAIL_MAX);
        unique case (state_q)
            IDLE: begin
                if (bit_valid) begin
                    bit_accept = 1'b1;
                    if (bit_cnt_q == BC_LAST) begin
                        entry_done = 1'b1;
                        state_d    = CHECK;
                    end
                end else if (bit_cnt_q != '0) begin
                    if (timer_q == TMO_LAST) begin
                        entry_tmo = 1'b1;
                    end else begin
                        idle_tick = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (code_match) begin
                    state_d = OPEN;
                end else if (lock_hit) begin
                    state_d = LOCKOUT;
                end else begin
                    state_d = IDLE;
                end
            end
            OPEN: begin
                if (lock_req || (timer_q == OPEN_LAST)) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer is shared: idle-gap counter in IDLE, window counter in OPEN/LOCKOUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q      <= '0;
            code_q       <= DEFAULT_CODE;
            bit_cnt_q    <= '0;
            timer_q      <= '0;
            fail_cnt_q   <= '0;
            fail_pulse_q <= 1'b0;
            prog_ack_q   <= 1'b0;
        end else begin
            fail_pulse_q <= 1'b0;
            prog_ack_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    unique case (1'b1)
                        bit_accept: begin
                            shift_q   <= CODE_LEN'({shift_q, bit_in});
                            timer_q   <= '0;
                            bit_cnt_q <= entry_done ? '0 : bit_cnt_q + 1'b1;
                        end
                        entry_tmo: begin
                            shift_q   <= '0;
                            bit_cnt_q <= '0;
                            timer_q   <= '0;
                        end
                        idle_tick: begin
                            timer_q <= timer_q + 1'b1;
                        end
                        default: ;
                    endcase
                end
                CHECK: begin
                    shift_q   <= '0;
                    bit_cnt_q <= '0;
                    timer_q   <= '0;
                    if (code_match) begin
                        fail_cnt_q <= '0;
                    end else begin
                        fail_pulse_q <= 1'b1;
                        fail_cnt_q   <= (fail_cnt_q == FAIL_MAX) ? FAIL_MAX : fail_next;
                    end
                end
                OPEN: begin
                    if (prog_req) begin
                        code_q     <= prog_code;
                        prog_ack_q <= 1'b1;
                    end
                    timer_q <= (state_d == OPEN) ? timer_q + 1'b1 : '0;
                end
                LOCKOUT: begin
                    if (state_d == LOCKOUT) begin
                        timer_q <= timer_q + 1'b1;
                    end else begin
                        timer_q    <= '0;
                        fail_cnt_q <= '0;
                        shift_q    <= '0;
                        bit_cnt_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign unlock     = (state_q == OPEN);
    assign locked_out = (state_q == LOCKOUT);
    assign fail_pulse = fail_pulse_q;
    assign prog_ack   = prog_ack_q;
    assign fail_count = fail_cnt_q;

endmodule

// File: tb/tb_lock_access_controller.sv
// Bench for lock_access_controller: directed scenarios plus randomized
// attempts, all checked cycle by cycle against a behavioural model.
module tb_lock_access_controller;

    localparam int OPEN_C = 8;
    localparam int LOCK_C = 16;
    localparam int TMO_C  = 6;
    localparam int MAXF   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid;
    logic       bit_in;
    logic       lock_req;
    logic       prog_req;
    logic [3:0] prog_code;
    logic       unlock;
    logic       locked_out;
    logic       fail_pulse;
    logic       prog_ack;
    logic [1:0] fail_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lock_access_controller #(
        .CODE_LEN       (4),
        .DEFAULT_CODE   (4'b1101),
        .MAX_FAILS      (MAXF),
        .OPEN_CYCLES    (OPEN_C),
        .LOCKOUT_CYCLES (LOCK_C),
        .ENTRY_TIMEOUT  (TMO_C),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .lock_req   (lock_req),
        .prog_req   (prog_req),
        .prog_code  (prog_code),
        .unlock     (unlock),
        .locked_out (locked_out),
        .fail_pulse (fail_pulse),
        .prog_ack   (prog_ack),
        .fail_count (fail_count)
    );

    // Reference model: entered bits, remaining window lengths, failures
    bit mq[$];
    int m_idle;
    int m_open;
    int m_lock;
    int m_fails;
    int m_code;
    bit m_pend;
    bit m_fp;
    bit m_ack;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_idle  = 0;
        m_open  = 0;
        m_lock  = 0;
        m_fails = 0;
        m_code  = 13;
        m_pend  = 1'b0;
        m_fp    = 1'b0;
        m_ack   = 1'b0;
    endtask

    task automatic model_step(input bit bv, input bit bi, input bit lr,
                              input bit pr, input int pc);
        int v;
        m_fp  = 1'b0;
        m_ack = 1'b0;
        if (m_pend) begin
            m_pend = 1'b0;
            v = 0;
            foreach (mq[i]) v = v * 2 + int'(mq[i]);
            mq.delete();
            m_idle = 0;
            if (v == m_code) begin
                m_open  = OPEN_C;
                m_fails = 0;
            end else begin
                m_fails++;
                m_fp = 1'b1;
                if (m_fails == MAXF) m_lock = LOCK_C;
            end
        end else if (m_open > 0) begin
            if (pr) begin
                m_code = pc;
                m_ack  = 1'b1;
            end
            m_open = lr ? 0 : m_open - 1;
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
        end else if (bv) begin
            mq.push_back(bi);
            m_idle = 0;
            if (mq.size() == 4) m_pend = 1'b1;
        end else if (mq.size() > 0) begin
            m_idle++;
            if (m_idle == TMO_C) begin
                mq.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("unlock", 32'(unlock), 32'(m_open > 0));
        chk("locked_out", 32'(locked_out), 32'(m_lock > 0));
        chk("fail_pulse", 32'(fail_pulse), 32'(m_fp));
        chk("prog_ack", 32'(prog_ack), 32'(m_ack));
        chk("fail_count", 32'(fail_count), 32'(m_fails));
    endtask

    task automatic cycle(input bit bv, input bit bi, input bit lr,
                         input bit pr, input logic [3:0] pc);
        bit_valid = bv;
        bit_in    = bi;
        lock_req  = lr;
        prog_req  = pr;
        prog_code = pc;
        @(posedge clk);
        model_step(bv, bi, lr, pr, int'(pc));
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic send(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) cycle(1'b1, c[i], 1'b0, 1'b0, 4'd0);
    endtask

    task automatic rcycle(input bit bv, input bit bi);
        cycle(bv, bi, $urandom_range(0, 11) == 0,
              $urandom_range(0, 9) == 0, 4'($urandom));
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        lock_req  = 1'b0;
        prog_req  = 1'b0;
        prog_code = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] c;
        int         kind;

        do_reset();
        chk("rst_unlock", 32'(unlock), 32'd0);
        chk("rst_locked_out", 32'(locked_out), 32'd0);
        chk("rst_fail_pulse", 32'(fail_pulse), 32'd0);
        chk("rst_prog_ack", 32'(prog_ack), 32'd0);
        chk("rst_fail_count", 32'(fail_count), 32'd0);

        send(4'b1101);
        idle(12);

        send(4'b1001);
        idle(2);
        send(4'b1101);
        idle(12);

        send(4'b1001);
        idle(1);
        send(4'b0000);
        idle(1);
        send(4'b1001);
        send(4'b1101);
        idle(20);
        send(4'b1101);
        idle(12);

        send(4'b1101);
        idle(1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        idle(2);
        send(4'b1101);
        idle(3);
        send(4'b0110);
        idle(12);

        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(6);
        send(4'b1101);
        idle(12);

        send(4'b1101);
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        idle(3);

        send(4'b1101);
        idle(2);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0011);
        idle(10);
        send(4'b1101);
        idle(2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_unlock", 32'(unlock), 32'd0);
        chk("async_rst_fail_count", 32'(fail_count), 32'd0);
        chk("async_rst_locked_out", 32'(locked_out), 32'd0);
        model_reset();
        bit_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send(4'b1101);
        idle(12);

        for (int a = 0; a < 300; a++) begin
            kind = int'($urandom_range(0, 3));
            c = (kind < 2) ? 4'(m_code) : 4'($urandom);
            for (int i = 3; i >= 0; i--) begin
                rcycle(1'b1, c[i]);
                if ($urandom_range(0, 7) == 0) begin
                    repeat ($urandom_range(1, 8)) rcycle(1'b0, 1'b0);
                end
            end
            repeat ($urandom_range(0, 10)) rcycle(1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
